// File: rtl/rt_vec_reduce.sv
// Horizontal reduction of one 3-lane signed fixed-point vector into a scalar
// (SUM or signed MAX), with a registered valid/ready result port.
module rt_vec_reduce #(
   parameter int WORD_LEN = 32,
   parameter int IW       = 16,
   parameter int QW       = 16,
   parameter bit SAT      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [3*WORD_LEN-1:0] in_vec,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_LEN-1:0]   out_data,
   output logic                  out_sat
);

   localparam int AW = WORD_LEN + 2;
   localparam logic signed [AW-1:0] POS_LIM = {3'b000, {(WORD_LEN-1){1'b1}}};
   localparam logic signed [AW-1:0] NEG_LIM = {3'b111, {(WORD_LEN-1){1'b0}}};

   generate
      if (IW + QW != WORD_LEN) begin : g_fmt_chk
         $error("rt_vec_reduce: IW + QW must equal WORD_LEN");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

   state_t               state;
   logic signed [AW-1:0] acc;
   logic [WORD_LEN-1:0]  lane1, lane2;
   logic                 mode;

   logic signed [AW-1:0] lane_x, sum_v, max_v, comb_v;
   logic [WORD_LEN-1:0]  res_data;
   logic                 res_sat;
   logic                 accept;

   assign in_ready = rst_n && (state == IDLE || (state == DONE && out_ready));
   assign accept   = in_valid && in_ready;

   // The wide accumulator holds any 3-term sum exactly; clamping happens only
   // on the final value.
   always_comb begin
      lane_x   = (state == ACC1) ? {{2{lane1[WORD_LEN-1]}}, lane1}
                                 : {{2{lane2[WORD_LEN-1]}}, lane2};
      sum_v    = acc + lane_x;
      max_v    = (lane_x > acc) ? lane_x : acc;
      comb_v   = mode ? max_v : sum_v;
      res_data = comb_v[WORD_LEN-1:0];
      res_sat  = 1'b0;
      if (!mode && SAT) begin
         if (comb_v > POS_LIM) begin
            res_data = POS_LIM[WORD_LEN-1:0];
            res_sat  = 1'b1;
         end else if (comb_v < NEG_LIM) begin
            res_data = NEG_LIM[WORD_LEN-1:0];
            res_sat  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         lane1     <= '0;
         lane2     <= '0;
         mode      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         if (state == DONE && out_ready)
            out_valid <= 1'b0;
         unique case (state)
            ACC1: begin
               acc   <= comb_v;
               state <= ACC2;
            end
            ACC2: begin
               acc       <= comb_v;
               out_data  <= res_data;
               out_sat   <= res_sat;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            default: begin
               if (accept) begin
                  acc   <= {{2{in_vec[WORD_LEN-1]}}, in_vec[WORD_LEN-1:0]};
                  lane1 <= in_vec[2*WORD_LEN-1:WORD_LEN];
                  lane2 <= in_vec[3*WORD_LEN-1:2*WORD_LEN];
                  mode  <= in_mode;
                  state <= ACC1;
               end else if (state == DONE && out_ready) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rt_vec_reduce.sv
// Directed bench for rt_vec_reduce: a saturating and a wrapping instance share
// the same stimulus; expected values are hand-computed constants.
module tb_rt_vec_reduce;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_mode;
   logic [95:0] in_vec;
   logic        out_ready;
   logic        in_ready, out_valid, out_sat;
   logic [31:0] out_data;
   logic        w_in_ready, w_out_valid, w_out_sat;
   logic [31:0] w_out_data;

   int unsigned total  = 0;
   int unsigned passed = 0;

   always #5 clk = ~clk;

   rt_vec_reduce #(.WORD_LEN(32), .IW(16), .QW(16), .SAT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_vec(in_vec), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
   );

   rt_vec_reduce #(.WORD_LEN(32), .IW(16), .QW(16), .SAT(1'b0)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_mode(in_mode), .in_vec(in_vec), .out_valid(w_out_valid),
      .out_ready(out_ready), .out_data(w_out_data), .out_sat(w_out_sat)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   // Full reduction with out_ready high; returns at the negedge while in DONE.
   task automatic reduce(input string tag, input logic [31:0] v0, v1, v2,
                         input logic md, input logic [31:0] e, input logic es,
                         input logic [31:0] ew, input logic ews);
      @(negedge clk);
      in_valid  = 1'b1;
      in_mode   = md;
      in_vec    = {v2, v1, v0};
      out_ready = 1'b1;
      #1 chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_vec   = '0;
      chk({tag, ".acc1_valid"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      chk({tag, ".acc2_valid"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ".data"}, out_data, e);
      chk({tag, ".sat"}, {31'b0, out_sat}, {31'b0, es});
      chk({tag, ".w_valid"}, {31'b0, w_out_valid}, 32'd1);
      chk({tag, ".w_data"}, w_out_data, ew);
      chk({tag, ".w_sat"}, {31'b0, w_out_sat}, {31'b0, ews});
      chk({tag, ".w_in_ready"}, {31'b0, w_in_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] sexp [4];
      sexp[0] = 32'h0003_0000; sexp[1] = 32'h0005_0000;
      sexp[2] = 32'h0007_0000; sexp[3] = 32'h0009_0000;

      rst_n = 1'b0; in_valid = 1'b1; in_mode = 1'b0; out_ready = 1'b1;
      in_vec = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
      repeat (3) @(negedge clk);
      chk("rst.valid", {31'b0, out_valid}, 32'd0);
      chk("rst.data", out_data, 32'd0);
      chk("rst.sat", {31'b0, out_sat}, 32'd0);
      chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1 chk("rst.in_ready_after", {31'b0, in_ready}, 32'd1);

      reduce("sum", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0,
             32'h0006_0000, 1'b0, 32'h0006_0000, 1'b0);
      reduce("sat_pos", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0,
             32'h7FFF_FFFF, 1'b1, 32'h7FFD_0000, 1'b0);
      reduce("sat_neg", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0,
             32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);
      reduce("recover", 32'h7FFF_0000, 32'h7FFF_0000, 32'h8001_0000, 1'b0,
             32'h7FFF_0000, 1'b0, 32'h7FFF_0000, 1'b0);
      reduce("max", 32'hFFFF_0000, 32'h0000_8000, 32'hFFFD_0000, 1'b1,
             32'h0000_8000, 1'b0, 32'h0000_8000, 1'b0);
      reduce("max_neg", 32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFD_0000, 1'b1,
             32'hFFFF_0000, 1'b0, 32'hFFFF_0000, 1'b0);

      // Backpressure: result held in DONE while an ignored vector is offered.
      @(negedge clk);
      in_valid = 1'b1; in_mode = 1'b0; out_ready = 1'b0;
      in_vec = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
      @(negedge clk);
      in_mode = 1'b1;
      in_vec = {32'hFFFF_0000, 32'h0004_0000, 32'h0005_0000};
      @(negedge clk);
      in_mode = 1'b0;
      @(negedge clk);
      chk("bp.valid", {31'b0, out_valid}, 32'd1);
      chk("bp.data", out_data, 32'h0003_0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp.hold_valid%0d", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("bp.hold_data%0d", i), out_data, 32'h0003_0000);
         chk($sformatf("bp.hold_sat%0d", i), {31'b0, out_sat}, 32'd0);
         chk($sformatf("bp.hold_ready%0d", i), {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1 chk("ovl.in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("ovl.acc1_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      chk("ovl.acc2_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      chk("ovl.valid", {31'b0, out_valid}, 32'd1);
      chk("ovl.data", out_data, 32'h0008_0000);

      // Streaming: in_valid held high, one result every 3 cycles.
      @(negedge clk);
      in_valid = 1'b1; in_mode = 1'b0;
      in_vec = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("str%0d.acc1_valid", i), {31'b0, out_valid}, 32'd0);
         @(negedge clk);
         chk($sformatf("str%0d.acc2_valid", i), {31'b0, out_valid}, 32'd0);
         @(negedge clk);
         chk($sformatf("str%0d.valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("str%0d.data", i), out_data, sexp[i]);
         chk($sformatf("str%0d.in_ready", i), {31'b0, in_ready}, 32'd1);
         if (i < 3) in_vec = {32'h0001_0000, 32'((i + 2) << 16), 32'((i + 2) << 16)};
         else in_valid = 1'b0;
      end

      // Abort mid-reduction with a 1-cycle reset.
      @(negedge clk);
      in_valid = 1'b1; in_mode = 1'b0;
      in_vec = {32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("abort.in_ready_low", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      chk("abort.valid", {31'b0, out_valid}, 32'd0);
      chk("abort.data", out_data, 32'd0);
      chk("abort.in_ready", {31'b0, in_ready}, 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1 chk("abort.in_ready_after", {31'b0, in_ready}, 32'd1);
      reduce("post_abort", 32'h0001_0000, 32'h0, 32'h0, 1'b0,
             32'h0001_0000, 1'b0, 32'h0001_0000, 1'b0);

      @(negedge clk);
      chk("final.idle_valid", {31'b0, out_valid}, 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
